// File: rtl/siggen_pkg.sv
// Shared types and helpers for the signal-generator sample RAM path.
// Holds the writer state enum, default widths and the modular address subtract.
package siggen_pkg;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_e;

  // (a - b) mod 2^w; callers truncate the result to their address width.
  function automatic logic [31:0] addr_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/ram_delay_ptr.sv
// Wrapping write pointer, saturating fill counter and registered wrap pulse
// for ram_delay_writer.
module ram_delay_ptr
  import siggen_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             accept,
  output logic [WIDTH-1:0] ptr,
  output logic [WIDTH:0]   fill_nxt,
  output logic             at_end,
  output logic             wrapped
);

  localparam logic [WIDTH:0] FILL_MAX = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH:0]   fill_q, fill_d, fill_inc;
  logic             wrapped_q, wrapped_d;

  always_comb begin
    fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    wrapped_d = 1'b0;
    if (clr) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      ptr_d     = ptr_q + 1'b1;
      fill_d    = fill_inc;
      wrapped_d = &ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign ptr      = ptr_q;
  assign fill_nxt = fill_inc;
  assign at_end   = &ptr_q;
  assign wrapped  = wrapped_q;

endmodule

// File: rtl/ram_delay_writer.sv
// Write-side address generator for the delay-line sample RAM.
// Optional single-buffer capture enabled by RAM_DELAY_WRITER_ONESHOT_EN.
module ram_delay_writer
  import siggen_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDR_W,
  parameter int unsigned DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-2:0]  offset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WIDTH-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [WIDTH-1:0]  rd_addr,
  output logic              delay_valid,
  output logic              wrapped
);

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic              dv_q, dv_d;

  logic              accept;
  logic              qualify;
  logic [WIDTH-1:0]  ptr;
  logic [WIDTH:0]    fill_nxt;
  logic              at_end;

  always_comb begin
`ifdef RAM_DELAY_WRITER_ONESHOT_EN
    in_ready = en && !clr && (state_q != DONE);
`else
    in_ready = en && !clr;
`endif
    accept = in_valid && in_ready;
  end

  ram_delay_ptr #(.WIDTH(WIDTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .accept   (accept),
    .ptr      (ptr),
    .fill_nxt (fill_nxt),
    .at_end   (at_end),
    .wrapped  (wrapped)
  );

  // Fill count including the sample being accepted now, against this cycle's offset.
  assign qualify = fill_nxt > {2'b00, offset};

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    dv_d      = dv_q;
    if (clr) begin
      state_d = IDLE;
      dv_d    = 1'b0;
    end else if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr;
      wr_data_d = in_data;
      rd_addr_d = WIDTH'(addr_sub(32'(ptr), 32'(offset), WIDTH));
      dv_d      = (state_q == RUN) || qualify;
      if (state_q != RUN) state_d = qualify ? RUN : FILL;
`ifdef RAM_DELAY_WRITER_ONESHOT_EN
      if (at_end) state_d = DONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      dv_q      <= dv_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_addr     = rd_addr_q;
  assign delay_valid = dv_q;

`ifndef RAM_DELAY_WRITER_ONESHOT_EN
  logic unused_at_end;
  assign unused_at_end = at_end;
`endif

endmodule

// File: doc/ram_delay_writer.md
Name: ram_delay_writer

Overview:
- Write-side address generator for the dual-port sample RAM used by the signal-generator/delay path.
- Accepts 8-bit samples on a valid/ready handshake and produces RAM write strobes with a wrapping write pointer.
- Derives the paired read address as write address minus a user offset, giving a programmable delay line.
- Flags when the delayed read data is meaningful, i.e. at least offset+1 samples have been written since the last clear.

Parameters:
- WIDTH, 9, RAM address width (512 entries).
- DATA_W, 8, sample width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  global enable; when low, no samples are accepted and all state holds
- clr  input  1  synchronous restart: pointer, fill count and state return to reset values
- offset  input  WIDTH-1  delay in samples (0..255)
- in_valid  input  1  sample present
- in_data  input  DATA_W  sample
- in_ready  output  1  block can accept a sample this cycle
- wr_en  output  1  RAM write strobe (registered)
- wr_addr  output  WIDTH  RAM write address (registered)
- wr_data  output  DATA_W  RAM write data (registered)
- rd_addr  output  WIDTH  RAM read address = wr_addr - offset mod 2^WIDTH (registered)
- delay_valid  output  1  rd_addr points at a sample written since the last clear
- wrapped  output  1  pulse, 1 cycle, on the write to address 2^WIDTH-1

Behaviour:
- Reset values:
  - All outputs are 0.
  - Internal write pointer ptr = 0, fill counter fill = 0, state = IDLE.
- Handshake:
  - in_ready = en && !clr && state != DONE (combinational).
  - accept = in_valid && in_ready.
  - in_valid may stay high across cycles without loss.
- Write latency is 1 cycle. On accept at edge N, the outputs after edge N are:
  - wr_en = 1, wr_addr = ptr, wr_data = in_data.
  - rd_addr = ptr - offset (WIDTH-bit modular subtract, offset zero-extended).
  - ptr <= ptr + 1, wrapping from 2^WIDTH-1 to 0.
- With no accept, wr_en = 0 and the other outputs hold their last values.
- fill counter:
  - WIDTH+1 bits, increments on accept, saturates at 2^WIDTH.
  - Not cleared by wrap.
- delay_valid:
  - Registered with the write.
  - Set to (fill_after_this_write > offset) using the offset sampled at that accept.
  - Sticky in RUN.
- State machine:
  - IDLE -> FILL on first accept.
  - FILL -> RUN on the accept that makes fill > offset (same edge delay_valid rises).
  - If offset = 0, the first accept goes IDLE -> RUN directly.
  - RUN stays in RUN; with the optional feature, RUN -> DONE (see below).
- Offset change mid-run: the new value affects the next rd_addr only. delay_valid is not cleared; the user must clr to re-qualify.
- clr has priority over accept. Asserting clr and in_valid together drops the sample: in_ready is 0 that cycle.
- en low: holds all state, wr_en = 0. wrapped is never asserted while idle.
- Async rst mid-write: outputs go to 0 immediately. The in-flight write strobe is lost.

Optional Feature:
- Macro: RAM_DELAY_WRITER_ONESHOT_EN.
- Defined: after the accept that writes address 2^WIDTH-1, the state goes to DONE.
  - In DONE, in_ready = 0 and wr_en = 0.
  - clr returns the state to IDLE.
  - Used for single-buffer capture.
- Undefined: the DONE state does not exist and the pointer wraps indefinitely.

Decomposition:
- Shared package siggen_pkg:
  - typedef of the state enum (IDLE, FILL, RUN, DONE).
  - Default constants ADDR_W = 9 and SAMPLE_W = 8.
  - A function for modular address subtract.
- One natural sub-module, ram_delay_ptr: holds the wrapping pointer, fill counter and wrap pulse. The FSM and output registers stay in the top.

Test Plan:
- Reset, then offset = 3, 5 back-to-back samples 0x10..0x14:
  - wr_addr = 0..4 one cycle after each accept.
  - rd_addr = 0x1FD, 0x1FE, 0x1FF, 0x000, 0x001.
  - delay_valid rises with the 4th write (wr_addr = 3).
- offset = 0, single sample 0xAA: wr_addr = 0, rd_addr = 0, delay_valid = 1 on the same cycle.
- 512 consecutive samples with offset = 255:
  - wrapped pulses exactly once, with wr_addr = 0x1FF.
  - The 513th write has wr_addr = 0 and rd_addr = 0x101.
- in_valid held high with en toggled 1,0,1: only 2 accepts; wr_en is low in the en = 0 cycle; ptr advances by 2.
- clr asserted with in_valid = 1 after 10 writes:
  - in_ready = 0 and no write that cycle.
  - Next accept gives wr_addr = 0 and delay_valid = 0.
- Async rst pulsed between clock edges mid-stream: outputs go to 0 before the next edge. With the macro defined, the full-buffer test ends in DONE with in_ready = 0 until clr.
